// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer. It drives an external WORD_W-bit
// adder slice one word per clock, least-significant word first. The carry
// is chained between words through a register.
//
// state | meaning
// IDLE  | waiting for operands; in_ready high, adder pins held at 0
// RUN   | one word per cycle through the external adder
// DONE  | result presented; held until the consumer accepts it
module mp_add_seq #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_W*NUM_WORDS-1:0]   in_a,
    input  logic [WORD_W*NUM_WORDS-1:0]   in_b,
    input  logic                          in_cin,
    input  logic                          in_sub,
    output logic [WORD_W-1:0]             add_a,
    output logic [WORD_W-1:0]             add_b,
    output logic                          add_cin,
    input  logic [WORD_W-1:0]             add_s,
    input  logic                          add_cout,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_W*NUM_WORDS-1:0]   out_sum,
    output logic                          out_cout,
    output logic                          out_ovf,
    output logic                          busy
);

    localparam int TW = WORD_W * NUM_WORDS;
    localparam int IW = $clog2(NUM_WORDS);
    localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [TW-1:0]   a_q, a_d;
    logic [TW-1:0]   b_q, b_d;       // B already inverted for subtract
    logic [TW-1:0]   sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: accept operands, step through words, hold result.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub ? 1'b1 : in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*WORD_W +: WORD_W] = add_s;
                carry_d = add_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    // Overflow: operands share a sign that the result lacks.
                    cout_d  = add_cout;
                    ovf_d   = (a_q[TW-1] == b_q[TW-1]) &&
                              (add_s[WORD_W-1] != a_q[TW-1]);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags and adder pins; pins are quiet outside RUN.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[idx_q*WORD_W +: WORD_W];
            add_b   = b_q[idx_q*WORD_W +: WORD_W];
            add_cin = carry_q;
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Bench for mp_add_seq with a behavioural adder slice and a result scoreboard.
module tb_mp_add_seq;

    localparam int WW = 32;
    localparam int NW = 4;
    localparam int TW = WW * NW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [TW-1:0] in_a = '0;
    logic [TW-1:0] in_b = '0;
    logic          in_cin = 1'b0;
    logic          in_sub = 1'b0;
    logic [WW-1:0] add_a, add_b, add_s;
    logic          add_cin, add_cout;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [TW-1:0] out_sum;
    logic          out_cout, out_ovf, busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [TW-1:0] s;
        logic          c;
        logic          o;
    } exp_t;
    exp_t exp_q[$];

    mp_add_seq #(.WORD_W(WW), .NUM_WORDS(NW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .busy(busy)
    );

    // External carry-select slice, modelled as a plain combinational adder.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{WW{1'b0}}, add_cin};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare whenever a result is handed over.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got result 0x%0h expected none", out_sum);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_sum", out_sum, e.s);
                chk("sb_cout", {{(TW-1){1'b0}}, out_cout}, {{(TW-1){1'b0}}, e.c});
                chk("sb_ovf", {{(TW-1){1'b0}}, out_ovf}, {{(TW-1){1'b0}}, e.o});
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic start_op(input logic [TW-1:0] a, input logic [TW-1:0] b,
                            input logic cin, input logic sub, input logic push,
                            input logic [TW-1:0] es, input logic ec, input logic eo);
        int t;
        exp_t e;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("accept_ready", {{(TW-1){1'b0}}, in_ready}, 1);
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_sub = sub;
        in_valid = 1'b1;
        if (push) begin
            e.s = es;
            e.c = ec;
            e.o = eo;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = ~a;
        in_b = ~b;
        in_cin = ~cin;
        chk("busy_after_accept", {{(TW-1){1'b0}}, busy}, 1);
    endtask

    // Watches the four RUN cycles and the DONE cycle, then returns in IDLE.
    task automatic run_watch(output logic [3:0] cins, output logic [WW-1:0] b0);
        cins = '0;
        b0 = '0;
        for (int k = 0; k < NW; k++) begin
            @(negedge clk);
            cins[k] = add_cin;
            if (k == 0) b0 = add_b;
            chk("no_early_valid", {{(TW-1){1'b0}}, out_valid}, 0);
        end
        @(negedge clk);
        chk("latency_valid", {{(TW-1){1'b0}}, out_valid}, 1);
        @(posedge clk);
        #1;
    endtask

    logic [3:0]    cins;
    logic [WW-1:0] b0;
    logic [TW-1:0] ones;

    initial begin
        ones = '1;
        #12;
        chk("rst_in_ready", {{(TW-1){1'b0}}, in_ready}, 1);
        chk("rst_out_valid", {{(TW-1){1'b0}}, out_valid}, 0);
        chk("rst_busy", {{(TW-1){1'b0}}, busy}, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_add_pins", {{(TW-WW*2-1){1'b0}}, add_a, add_b, add_cin}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Carry ripples out of word 1 into word 2.
        start_op(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0, 1'b1,
                 128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0, 1'b0);
        run_watch(cins, b0);
        chk("cin_seq", {{(TW-4){1'b0}}, cins}, {{(TW-4){1'b0}}, 4'b0110});

        // Full wrap: all ones + 0 + 1.
        start_op(ones, 128'h0, 1'b1, 1'b0, 1'b1, 128'h0, 1'b1, 1'b0);
        run_watch(cins, b0);

        // 5 - 7 with borrow.
        start_op(128'h5, 128'h7, 1'b0, 1'b1, 1'b1,
                 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_watch(cins, b0);
        chk("sub_cin0", {{(TW-1){1'b0}}, cins[0]}, 1);
        chk("sub_b0", {{(TW-WW){1'b0}}, b0}, {{(TW-WW){1'b0}}, 32'hFFFF_FFF8});

        // Signed overflow: max positive + 1.
        start_op(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0, 1'b1,
                 128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1);
        run_watch(cins, b0);

        // Backpressure, plus a request presented mid-RUN that must be ignored.
        out_ready = 1'b0;
        start_op(128'h10, 128'h20, 1'b0, 1'b0, 1'b1, 128'h30, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a = 128'h1234;
        in_b = 128'h5678;
        in_sub = 1'b1;
        @(negedge clk);
        chk("run_in_ready", {{(TW-1){1'b0}}, in_ready}, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid", {{(TW-1){1'b0}}, out_valid}, 1);
            chk("bp_sum", out_sum, 128'h30);
            chk("bp_in_ready", {{(TW-1){1'b0}}, in_ready}, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_hs", {{(TW-1){1'b0}}, in_ready}, 1);
        chk("idle_busy", {{(TW-1){1'b0}}, busy}, 0);
        start_op(128'h1, 128'h2, 1'b0, 1'b0, 1'b1, 128'h3, 1'b0, 1'b0);
        run_watch(cins, b0);

        // Reset during RUN cycle 2 aborts the operation.
        start_op(128'h9, 128'h9, 1'b0, 1'b0, 1'b0, 128'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_in_ready", {{(TW-1){1'b0}}, in_ready}, 1);
        chk("abort_busy", {{(TW-1){1'b0}}, busy}, 0);
        chk("abort_valid", {{(TW-1){1'b0}}, out_valid}, 0);
        chk("abort_add_pins", {{(TW-WW*2-1){1'b0}}, add_a, add_b, add_cin}, 0);
        chk("abort_sum", out_sum, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_op(128'h3, 128'h4, 1'b0, 1'b0, 1'b1, 128'h7, 1'b0, 1'b0);
        run_watch(cins, b0);

        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
